// File: rtl/cpu7_exu_wb_arb.sv
// cpu7_exu_wb_arb: writeback arbiter for the single irf write port.
// Merges ALU and LSU M-stage results through a small in-order FIFO so that
// colliding writes are serialised instead of one of them being lost.
module cpu7_exu_wb_arb #(
  parameter int GRLEN     = 32,
  parameter int DEPTH     = 4,
  parameter int STALL_THR = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_wb_valid_m,
  input  logic [4:0]                 alu_wb_rd_m,
  input  logic [GRLEN-1:0]           alu_wb_data_m,
  input  logic                       lsu_wb_valid_m,
  input  logic [4:0]                 lsu_wb_rd_m,
  input  logic [GRLEN-1:0]           lsu_wb_data_m,
  output logic                       wb_irf_wen_w,
  output logic [4:0]                 wb_irf_rd_w,
  output logic [GRLEN-1:0]           wb_irf_rd_data_w,
  output logic                       wb_ifu_stall_req,
  output logic [$clog2(DEPTH):0]     wb_fifo_cnt,
  output logic                       wb_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]       rd;
    logic [GRLEN-1:0] data;
  } wb_ent_t;

  wb_ent_t          r_mem [DEPTH];
  logic [AW-1:0]    r_rptr, r_wptr;
  logic [CW-1:0]    r_cnt;
  logic             r_wen, r_ovf;
  logic [4:0]       r_rd;
  logic [GRLEN-1:0] r_data;

  logic             w_lsu_ok, w_alu_ok, w_fifo_ne;
  wb_ent_t          w_lsu_e, w_alu_e, w_pop_e, w_p0, w_p1;
  logic             w_pop_vld, w_p0_vld, w_p1_vld, w_p1_acc, w_drop;
  logic [1:0]       w_n_push;
  logic [CW-1:0]    w_cnt_nxt;

  // Candidate selection: FIFO head first, then LSU, then ALU; leftovers are pushed in order
  always_comb begin
    w_lsu_ok  = lsu_wb_valid_m && (lsu_wb_rd_m != 5'd0);
    w_alu_ok  = alu_wb_valid_m && (alu_wb_rd_m != 5'd0);
    w_fifo_ne = (r_cnt != '0);
    w_lsu_e   = {lsu_wb_rd_m, lsu_wb_data_m};
    w_alu_e   = {alu_wb_rd_m, alu_wb_data_m};
    w_pop_vld = w_fifo_ne || w_lsu_ok || w_alu_ok;
    w_pop_e   = w_alu_e;
    w_p0      = w_alu_e;
    w_p1      = w_alu_e;
    w_p0_vld  = 1'b0;
    w_p1_vld  = 1'b0;
    if (w_fifo_ne) begin
      w_pop_e = r_mem[r_rptr];
      if (w_lsu_ok) begin
        w_p0     = w_lsu_e;
        w_p0_vld = 1'b1;
        w_p1_vld = w_alu_ok;
      end else begin
        w_p0_vld = w_alu_ok;
      end
    end else if (w_lsu_ok) begin
      w_pop_e  = w_lsu_e;
      w_p0_vld = w_alu_ok;
    end
    // Only a full FIFO receiving two pushes can overrun; the ALU (youngest) loses
    w_drop    = w_p1_vld && (r_cnt == CW'(DEPTH));
    w_p1_acc  = w_p1_vld && !w_drop;
    w_n_push  = {1'b0, w_p0_vld} + {1'b0, w_p1_acc};
    w_cnt_nxt = r_cnt - CW'(w_fifo_ne) + CW'(w_n_push);
  end

  // FIFO storage: data path only, no reset needed
  always_ff @(posedge clk) begin
    if (w_p0_vld) r_mem[r_wptr]          <= w_p0;
    if (w_p1_acc) r_mem[r_wptr + AW'(1)] <= w_p1;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_rptr <= r_rptr + AW'(w_fifo_ne);
      r_wptr <= r_wptr + AW'(w_n_push);
      r_cnt  <= w_cnt_nxt;
      r_ovf  <= r_ovf | w_drop;
    end
  end

  // W-stage write port; address/data hold when nothing is written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen  <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      r_wen <= w_pop_vld;
      if (w_pop_vld) begin
        r_rd   <= w_pop_e.rd;
        r_data <= w_pop_e.data;
      end
    end
  end

  assign wb_irf_wen_w     = r_wen;
  assign wb_irf_rd_w      = r_rd;
  assign wb_irf_rd_data_w = r_data;
  assign wb_fifo_cnt      = r_cnt;
  assign wb_overflow      = r_ovf;
  assign wb_ifu_stall_req = (r_cnt >= CW'(STALL_THR));
endmodule

// File: tb/tb_cpu7_exu_wb_arb.sv
// Scoreboard bench for cpu7_exu_wb_arb: stimulus pushes expected irf writes,
// a negedge monitor pops and compares each write the DUT performs.
module tb_cpu7_exu_wb_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_v = 1'b0, lsu_v = 1'b0;
  logic [4:0]  alu_rd = '0, lsu_rd = '0;
  logic [31:0] alu_d = '0, lsu_d = '0;
  logic        wen, stall, ovf;
  logic [4:0]  wrd;
  logic [31:0] wdata;
  logic [2:0]  cnt;

  int tests = 0;
  int fails = 0;
  logic [36:0] expq[$];

  cpu7_exu_wb_arb #(.GRLEN(32), .DEPTH(4), .STALL_THR(2)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid_m(alu_v), .alu_wb_rd_m(alu_rd), .alu_wb_data_m(alu_d),
    .lsu_wb_valid_m(lsu_v), .lsu_wb_rd_m(lsu_rd), .lsu_wb_data_m(lsu_d),
    .wb_irf_wen_w(wen), .wb_irf_rd_w(wrd), .wb_irf_rd_data_w(wdata),
    .wb_ifu_stall_req(stall), .wb_fifo_cnt(cnt), .wb_overflow(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [4:0] rd, input logic [31:0] d);
    expq.push_back({rd, d});
  endtask

  // Apply one cycle of requests, then return 1ns after the sampling edge
  task automatic drive(input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad);
    lsu_v = lv; lsu_rd = lr; lsu_d = ld;
    alu_v = av; alu_rd = ar; alu_d = ad;
    @(posedge clk); #1;
    lsu_v = 1'b0; alu_v = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: every performed write must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && wen) begin
      if (expq.size() == 0) begin
        chk("unexpected_write", {wrd, wdata}, 37'd0);
        if ({wrd, wdata} == 37'd0) begin
          fails++;
          $display("FAIL unexpected_write: got wen=1 expected wen=0");
        end
      end else begin
        chk("irf_write", {wrd, wdata}, expq.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", 37'(wen), 37'd0);
    chk("rst_rd_data", {wrd, wdata}, 37'd0);
    chk("rst_cnt", 37'(cnt), 37'd0);
    chk("rst_stall_ovf", {35'd0, stall, ovf}, 37'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // ALU only: bypass, cnt stays 0, then rd/data hold on an idle cycle
    exp_wr(5'd5, 32'h11);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11);
    chk("alu_only_cnt", 37'(cnt), 37'd0);
    idle();
    chk("idle_wen", 37'(wen), 37'd0);
    chk("idle_hold", {wrd, wdata}, {5'd5, 32'h11});

    // Collision: load first, ALU next cycle; cnt=1 only in between
    exp_wr(5'd3, 32'hAA); exp_wr(5'd4, 32'hBB);
    drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB);
    chk("coll_cnt1", 37'(cnt), 37'd1);
    idle();
    chk("coll_cnt0", 37'(cnt), 37'd0);
    idle();

    // Same rd: both writes performed, load first
    exp_wr(5'd7, 32'd1); exp_wr(5'd7, 32'd2);
    drive(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
    idle(); idle();

    // Back-to-back collisions: cnt 1,2,3 with stall from cnt=2, then drain
    for (int i = 0; i < 3; i++) begin
      exp_wr(5'(1 + 2*i), 32'h100 + 32'(i));
      exp_wr(5'(2 + 2*i), 32'h180 + 32'(i));
      drive(1'b1, 5'(1 + 2*i), 32'h100 + 32'(i), 1'b1, 5'(2 + 2*i), 32'h180 + 32'(i));
      chk("b2b_cnt", 37'(cnt), 37'(i + 1));
      chk("b2b_stall", 37'(stall), 37'(i >= 1));
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("drain_cnt", 37'(cnt), 37'(2 - i));
    end
    chk("b2b_no_ovf", 37'(ovf), 37'd0);
    idle();

    // rd==0 filtering
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
    chk("rd0_wen", 37'(wen), 37'd0);
    chk("rd0_cnt", 37'(cnt), 37'd0);
    exp_wr(5'd9, 32'h99);
    drive(1'b1, 5'd0, 32'hBEEF, 1'b1, 5'd9, 32'h99);
    chk("rd0_lsu_cnt", 37'(cnt), 37'd0);
    idle();

    // Overflow: five collisions ignoring stall; fifth ALU result is dropped
    for (int i = 0; i < 5; i++) begin
      exp_wr(5'(10 + 2*i), 32'h200 + 32'(i));
      if (i < 4) exp_wr(5'(11 + 2*i), 32'h300 + 32'(i));
      drive(1'b1, 5'(10 + 2*i), 32'h200 + 32'(i), 1'b1, 5'(11 + 2*i), 32'h300 + 32'(i));
      chk("ovf_cnt", 37'(cnt), 37'((i < 4) ? i + 1 : 4));
      chk("ovf_flag", 37'(ovf), 37'(i == 4));
    end
    repeat (4) idle();
    chk("ovf_drained", 37'(cnt), 37'd0);
    chk("ovf_sticky", 37'(ovf), 37'd1);
    idle();

    // Async reset with cnt=3 clears everything immediately
    for (int i = 0; i < 3; i++) begin
      exp_wr(5'(20 + i), 32'h400 + 32'(i));
      exp_wr(5'(25 + i), 32'h500 + 32'(i));
      drive(1'b1, 5'(20 + i), 32'h400 + 32'(i), 1'b1, 5'(25 + i), 32'h500 + 32'(i));
    end
    chk("pre_rst_cnt", 37'(cnt), 37'd3);
    rst = 1'b1;
    #1;
    expq.delete();
    chk("arst_cnt", 37'(cnt), 37'd0);
    chk("arst_wen_stall", {35'd0, wen, stall}, 37'd0);
    chk("arst_ovf", 37'(ovf), 37'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) idle();
    chk("post_rst_no_write", 37'(wen), 37'd0);
    chk("queue_empty", 37'(expq.size()), 37'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
